// File: rtl/conv_row_pe.sv
// Row PE: holds one 5-tap weight row, slides it over a 7-pixel ifmap row, emits packed 8-bit products.
// Toggle req/ack on both sides; no pixel is taken while a product word is outstanding.
module conv_row_pe #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 5,
  parameter int MAP_W  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_load,
  input  logic [TAPS*DATA_W-1:0] w_data,
  output logic                   w_ready,
  input  logic                   in_req,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ack,
  output logic                   out_req,
  output logic [TAPS*DATA_W-1:0] out_data,
  input  logic                   out_ack,
  output logic                   row_done,
  output logic                   busy
);

  localparam int COL_W = $clog2(MAP_W + 1);
  localparam logic [COL_W-1:0] TAPS_C  = COL_W'(TAPS);
  localparam logic [COL_W-1:0] MAP_W_C = COL_W'(MAP_W);

  typedef enum logic [1:0] {S_NOWGT, S_ACCEPT, S_MUL, S_SEND} state_t;

  state_t                   r_state, w_state_nxt;
  logic [DATA_W-1:0]        r_w   [TAPS];
  logic [DATA_W-1:0]        r_win [TAPS];
  logic [COL_W-1:0]         r_col;
  logic                     r_in_ack, r_out_req, r_row_done;
  logic [TAPS*DATA_W-1:0]   r_out_data;

  logic                     w_pending, w_ready_int;
  logic [COL_W-1:0]         w_col_inc;
  logic                     w_wgt_lat, w_pix_acc, w_do_mul, w_row_end;
  logic [DATA_W-1:0]        w_prod [TAPS];

  assign w_pending   = (in_req != r_in_ack);
  assign w_ready_int = (r_state == S_NOWGT) || ((r_state == S_ACCEPT) && (r_col == '0));
  assign w_col_inc   = r_col + 1'b1;

  assign w_ready  = w_ready_int;
  assign busy     = ~w_ready_int;
  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign row_done = r_row_done;

  // Products are kept to DATA_W bits: the adder stage only takes the low byte.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_prod[i] = r_win[i] * r_w[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_NOWGT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wgt_lat   = 1'b0;
    w_pix_acc   = 1'b0;
    w_do_mul    = 1'b0;
    w_row_end   = 1'b0;
    case (r_state)
      S_NOWGT: begin
        if (w_load) begin
          w_wgt_lat   = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        // A weight load wins over a pending pixel; the pixel waits one cycle.
        if (w_load && w_ready_int) begin
          w_wgt_lat = 1'b1;
        end else if (w_pending) begin
          w_pix_acc = 1'b1;
          if (w_col_inc >= TAPS_C) w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        w_do_mul    = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (out_ack == r_out_req) begin
          w_state_nxt = S_ACCEPT;
          w_row_end   = (r_col == MAP_W_C);
        end
      end
      default: w_state_nxt = S_NOWGT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_w[i]   <= '0;
        r_win[i] <= '0;
      end
      r_col      <= '0;
      r_in_ack   <= 1'b0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= w_row_end;
      if (w_wgt_lat) begin
        for (int i = 0; i < TAPS; i++) r_w[i] <= w_data[i*DATA_W +: DATA_W];
      end
      if (w_pix_acc) begin
        for (int i = 0; i < TAPS-1; i++) r_win[i] <= r_win[i+1];
        r_win[TAPS-1] <= in_data;
        r_in_ack      <= in_req;
        r_col         <= w_col_inc;
      end
      if (w_do_mul) begin
        for (int i = 0; i < TAPS; i++) r_out_data[i*DATA_W +: DATA_W] <= w_prod[i];
        r_out_req <= ~r_out_req;
      end
      if (w_row_end) begin
        r_col <= '0;
        for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_row_pe.sv
// Directed bench for conv_row_pe: hand-computed product words, handshake latency, weight gating, reset.
module tb_conv_row_pe;

  logic        clk;
  logic        reset;
  logic        w_load;
  logic [39:0] w_data;
  logic        w_ready;
  logic        in_req;
  logic [7:0]  in_data;
  logic        in_ack;
  logic        out_req;
  logic [39:0] out_data;
  logic        out_ack;
  logic        row_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  conv_row_pe dut (
    .clk      (clk),
    .reset    (reset),
    .w_load   (w_load),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .row_done (row_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk40(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one pixel; it must be acknowledged at the very next edge.
  task automatic pix(input logic [7:0] p);
    in_data = p;
    in_req  = ~in_req;
    tick();
    chk1("in_ack_latency", in_ack, in_req);
  endtask

  task automatic load(input logic [39:0] w);
    w_data = w;
    w_load = 1'b1;
    tick();
    w_load = 1'b0;
  endtask

  task automatic word(input logic [39:0] e);
    tick();
    chk1("out_pending", out_req ^ out_ack, 1'b1);
    chk40("out_data", out_data, e);
    chk1("busy_send", busy, 1'b1);
  endtask

  task automatic ack(input logic last);
    out_ack = out_req;
    tick();
    chk1("row_done", row_done, last);
    if (last) begin
      tick();
      chk1("row_done_pulse", row_done, 1'b0);
      chk1("w_ready_row_end", w_ready, 1'b1);
    end
  endtask

  initial begin
    reset   = 1'b0;
    w_load  = 1'b0;
    w_data  = '0;
    in_req  = 1'b0;
    in_data = '0;
    out_ack = 1'b0;

    @(negedge clk);
    chk1("rst_in_ack", in_ack, 1'b0);
    chk1("rst_out_req", out_req, 1'b0);
    chk40("rst_out_data", out_data, 40'h0);
    chk1("rst_row_done", row_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_w_ready", w_ready, 1'b1);
    reset = 1'b1;
    tick();

    // Unit weights, pixels 1..7
    load(40'h0101010101);
    chk1("w_ready_col0", w_ready, 1'b1);
    chk1("busy_col0", busy, 1'b0);
    pix(8'd1);
    chk1("w_ready_col1", w_ready, 1'b0);
    chk1("busy_col1", busy, 1'b1);
    for (int k = 2; k <= 5; k++) pix(8'(k));
    word(40'h0504030201);
    ack(1'b0);
    pix(8'd6);
    word(40'h0605040302);
    ack(1'b0);
    pix(8'd7);
    word(40'h0706050403);
    ack(1'b1);

    // Truncation: 0x10*0x10 = 0x100 -> 0x00
    load(40'h1010101010);
    for (int k = 0; k < 5; k++) pix(8'h10);
    word(40'h0);
    ack(1'b0);
    pix(8'h10);
    word(40'h0);
    ack(1'b0);
    pix(8'h10);
    word(40'h0);
    ack(1'b1);

    // 0x03*0x55 = 0xFF
    load(40'h0303030303);
    for (int k = 0; k < 5; k++) pix(8'h55);
    word(40'hFFFFFFFFFF);
    ack(1'b0);
    pix(8'h55);
    word(40'hFFFFFFFFFF);
    ack(1'b0);
    pix(8'h55);
    word(40'hFFFFFFFFFF);
    ack(1'b1);

    // Backpressure: pixel 6 offered while window 1 is still unacknowledged
    load(40'h0101010101);
    for (int k = 1; k <= 5; k++) pix(8'(k));
    word(40'h0504030201);
    in_data = 8'd6;
    in_req  = ~in_req;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("in_ack_held", in_ack != in_req, 1'b1);
    end
    out_ack = out_req;
    tick();
    chk1("in_ack_held_on_ack", in_ack != in_req, 1'b1);
    tick();
    chk1("in_ack_released", in_ack, in_req);
    word(40'h0605040302);
    ack(1'b0);
    pix(8'd7);
    word(40'h0706050403);
    ack(1'b1);

    // Weight load mid-row must be ignored
    pix(8'd1);
    pix(8'd2);
    chk1("w_ready_col2", w_ready, 1'b0);
    load(40'hFFFFFFFFFF);
    for (int k = 3; k <= 5; k++) pix(8'(k));
    word(40'h0504030201);
    ack(1'b0);
    pix(8'd6);
    word(40'h0605040302);
    ack(1'b0);
    pix(8'd7);
    word(40'h0706050403);
    ack(1'b1);

    // Reset while a word is outstanding
    for (int k = 1; k <= 5; k++) pix(8'(k));
    word(40'h0504030201);
    reset = 1'b0;
    #1;
    chk1("mid_rst_in_ack", in_ack, 1'b0);
    chk1("mid_rst_out_req", out_req, 1'b0);
    chk40("mid_rst_out_data", out_data, 40'h0);
    chk1("mid_rst_row_done", row_done, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_w_ready", w_ready, 1'b1);
    in_req  = 1'b0;
    out_ack = 1'b0;
    tick();
    reset = 1'b1;

    // Pixels before any weight load are not taken
    in_data = 8'd9;
    in_req  = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk1("nowgt_in_ack", in_ack, 1'b0);
    chk1("nowgt_busy", busy, 1'b0);
    load(40'h0202020202);
    chk1("load_cycle_in_ack", in_ack, 1'b0);
    tick();
    chk1("post_load_in_ack", in_ack, 1'b1);
    for (int k = 1; k <= 4; k++) pix(8'(k));
    word(40'h0806040212);
    ack(1'b0);
    pix(8'd5);
    word(40'h0A08060402);
    ack(1'b0);
    pix(8'd6);
    word(40'h0C0A080604);
    ack(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
